// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin request arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rr_arb_pkg;

  // Arbiter FSM: one transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Why the FSM went through ABORT; only a timeout reports back to the port.
  typedef enum logic {
    CAUSE_REQ     = 1'b0,
    CAUSE_TIMEOUT = 1'b1
  } abort_cause_t;

  // Widths for the default configuration (4 ports, 1024-cycle watchdog).
  // Modules derive their own widths from their parameters with idx_w().
  localparam int GW = $clog2(4);
  localparam int CW = $clog2(1024);

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotating-priority encoder, first set req bit after last.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is eligible.
//   req   : request vector, one bit per port
//   last  : index of the most recent winner (search starts at last+1)
//   any   : at least one request bit is set
//   grant : index of the winning port (0 when any=0)
module rr_priority_pick #(
  parameter int PORTS = 4,
  parameter int GW    = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [GW-1:0]    last,
  output logic             any,
  output logic [GW-1:0]    grant
);

  int            cand;
  logic [GW-1:0] cand_idx;

  // Walk from the farthest candidate back to last+1 so the closest
  // requester after last overwrites everything found before it.
  always_comb begin
    any      = 1'b0;
    grant    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = PORTS; i >= 1; i--) begin
      cand = int'(last) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      cand_idx = GW'(cand);
      if (req[cand_idx]) begin
        any   = 1'b1;
        grant = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin share of one memory-side request target.
// Latency: Valid at t -> pending at t+1 -> OutReq_Valid at t+2; Done is
//          forwarded to the owning port combinationally.
// Backpressure: no grant while OutResp_Ready=0; each port holds one pending
//          request and further Valids on a pending port are dropped.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   InReq_*         : per-port request capture (Valid/Addr/DataType/Abort)
//   InResp_*        : per-port Done/Err pulses, Ready copy, shared Data
//   OutReq_*        : registered request to the target
//   OutResp_*       : target Done/Ready/Data
//   Grant_Id        : port currently or most recently granted
module rr_req_arbiter
  import rr_arb_pkg::*;
#(
  parameter int PORTS           = 4,
  parameter int ADDR_WIDTH      = 56,
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_TYPE_WIDTH = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORTS-1:0]                   InReq_Valid,
  input  logic [PORTS*ADDR_WIDTH-1:0]        InReq_Addr,
  input  logic [PORTS*DATA_TYPE_WIDTH-1:0]   InReq_DataType,
  input  logic [PORTS-1:0]                   InReq_Abort,
  output logic [PORTS-1:0]                   InResp_Done,
  output logic [PORTS-1:0]                   InResp_Err,
  output logic [PORTS-1:0]                   InResp_Ready,
  output logic [DATA_WIDTH-1:0]              InResp_Data,
  output logic                               OutReq_Valid,
  output logic [ADDR_WIDTH-1:0]              OutReq_Addr,
  output logic [DATA_TYPE_WIDTH-1:0]         OutReq_DataType,
  output logic                               OutReq_Abort,
  input  logic                               OutResp_Done,
  input  logic                               OutResp_Ready,
  input  logic [DATA_WIDTH-1:0]              OutResp_Data,
  output logic [idx_w(PORTS)-1:0]            Grant_Id
);

  localparam int GRANT_W = idx_w(PORTS);
  localparam int CNT_W   = idx_w(TIMEOUT_CYCLES);

  arb_state_t                 state;
  abort_cause_t               cause;
  logic [PORTS-1:0]           pend;
  logic [PORTS-1:0]           pend_nxt;
  logic [ADDR_WIDTH-1:0]      lat_addr [PORTS];
  logic [DATA_TYPE_WIDTH-1:0] lat_type [PORTS];
  logic [GRANT_W-1:0]         last_grant;
  logic [GRANT_W-1:0]         gid;
  logic [CNT_W-1:0]           wd_cnt;
  logic                       pick_any;
  logic [GRANT_W-1:0]         pick_idx;
  logic [PORTS-1:0]           pick_req;
  logic                       busy_done;
  logic                       busy_rabort;
  logic                       busy_tmo;

  // A port aborting this cycle must not win the grant it is cancelling.
  assign pick_req = pend & ~InReq_Abort;

  rr_priority_pick #(
    .PORTS (PORTS),
    .GW    (GRANT_W)
  ) u_pick (
    .req   (pick_req),
    .last  (last_grant),
    .any   (pick_any),
    .grant (pick_idx)
  );

  // Done beats a same-cycle requester abort; a requester abort beats the
  // watchdog so a port that cancelled never sees an error pulse.
  // The watchdog holds wd_cnt = n-1 in the n-th BUSY cycle, so the abort
  // follows TIMEOUT_CYCLES full BUSY cycles without Done.
  assign busy_done   = (state == BUSY) && OutResp_Done;
  assign busy_rabort = (state == BUSY) && !OutResp_Done && InReq_Abort[gid];
  assign busy_tmo    = (state == BUSY) && !OutResp_Done && !InReq_Abort[gid] &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Pending bits: abort clears, valid sets (a no-op when already pending),
  // and the owning port is released when its transaction ends.
  always_comb begin
    pend_nxt = pend;
    for (int p = 0; p < PORTS; p++) begin
      if (InReq_Abort[p])      pend_nxt[p] = 1'b0;
      else if (InReq_Valid[p]) pend_nxt[p] = 1'b1;
    end
    if (busy_done || busy_rabort || busy_tmo) pend_nxt[gid] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int p = 0; p < PORTS; p++) begin
        lat_addr[p] <= '0;
        lat_type[p] <= '0;
      end
    end else begin
      pend <= pend_nxt;
      // First request sticks: the latch only loads on an idle port.
      for (int p = 0; p < PORTS; p++) begin
        if (InReq_Valid[p] && !pend[p] && !InReq_Abort[p]) begin
          lat_addr[p] <= InReq_Addr[p*ADDR_WIDTH +: ADDR_WIDTH];
          lat_type[p] <= InReq_DataType[p*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cause           <= CAUSE_REQ;
      last_grant      <= GRANT_W'(PORTS - 1);
      gid             <= '0;
      wd_cnt          <= '0;
      OutReq_Valid    <= 1'b0;
      OutReq_Addr     <= '0;
      OutReq_DataType <= '0;
      OutReq_Abort    <= 1'b0;
    end else begin
      OutReq_Abort <= 1'b0;
      case (state)
        IDLE: begin
          if (OutResp_Ready && pick_any) begin
            state           <= BUSY;
            gid             <= pick_idx;
            wd_cnt          <= '0;
            OutReq_Valid    <= 1'b1;
            OutReq_Addr     <= lat_addr[pick_idx];
            OutReq_DataType <= lat_type[pick_idx];
          end
        end
        BUSY: begin
          if (busy_done) begin
            state        <= IDLE;
            last_grant   <= gid;
            OutReq_Valid <= 1'b0;
          end else if (busy_rabort || busy_tmo) begin
            state        <= ABORT;
            cause        <= busy_tmo ? CAUSE_TIMEOUT : CAUSE_REQ;
            last_grant   <= gid;
            OutReq_Valid <= 1'b0;
            OutReq_Abort <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ABORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response routing: only the owning port sees Done; a timeout completes
  // the transaction with an error and zero data.
  always_comb begin
    InResp_Done = '0;
    InResp_Err  = '0;
    InResp_Data = '0;
    if (state == BUSY) begin
      InResp_Data      = OutResp_Data;
      InResp_Done[gid] = OutResp_Done;
    end else if (state == ABORT && cause == CAUSE_TIMEOUT) begin
      InResp_Done[gid] = 1'b1;
      InResp_Err[gid]  = 1'b1;
    end
  end

  // Held low while reset is asserted so every output reads zero.
  assign InResp_Ready = rst ? '0 : {PORTS{OutResp_Ready}};
  assign Grant_Id     = gid;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed vectors, a transaction-level model
// checked every cycle, and literal expectations at key cycles.
module tb_rr_req_arbiter;

  localparam int P  = 4;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int TO = 8;
  localparam int GWB = 2;

  logic              clk;
  logic              rst;
  logic [P-1:0]      InReq_Valid;
  logic [P*AW-1:0]   InReq_Addr;
  logic [P*TW-1:0]   InReq_DataType;
  logic [P-1:0]      InReq_Abort;
  logic [P-1:0]      InResp_Done;
  logic [P-1:0]      InResp_Err;
  logic [P-1:0]      InResp_Ready;
  logic [DW-1:0]     InResp_Data;
  logic              OutReq_Valid;
  logic [AW-1:0]     OutReq_Addr;
  logic [TW-1:0]     OutReq_DataType;
  logic              OutReq_Abort;
  logic              OutResp_Done;
  logic              OutResp_Ready;
  logic [DW-1:0]     OutResp_Data;
  logic [GWB-1:0]    Grant_Id;

  rr_req_arbiter #(
    .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DATA_TYPE_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .InReq_Valid(InReq_Valid), .InReq_Addr(InReq_Addr),
    .InReq_DataType(InReq_DataType), .InReq_Abort(InReq_Abort),
    .InResp_Done(InResp_Done), .InResp_Err(InResp_Err),
    .InResp_Ready(InResp_Ready), .InResp_Data(InResp_Data),
    .OutReq_Valid(OutReq_Valid), .OutReq_Addr(OutReq_Addr),
    .OutReq_DataType(OutReq_DataType), .OutReq_Abort(OutReq_Abort),
    .OutResp_Done(OutResp_Done), .OutResp_Ready(OutResp_Ready),
    .OutResp_Data(OutResp_Data), .Grant_Id(Grant_Id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level model: which port owns the target, how many BUSY
  // cycles it has used, and whether this cycle is an abort cycle.
  bit            m_pend [P];
  logic [AW-1:0] m_addr [P];
  logic [TW-1:0] m_type [P];
  int m_cur;    // owning port, -1 when the target is free
  int m_last;   // port that most recently finished or aborted
  int m_gid;    // port most recently granted
  int m_age;    // 1-based BUSY cycle count of the current transaction
  int m_phase;  // 0 running, 1 requester abort cycle, 2 timeout abort cycle

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_pend[p] = 1'b0; m_addr[p] = '0; m_type[p] = '0;
    end
    m_cur = -1; m_last = P - 1; m_gid = 0; m_age = 0; m_phase = 0;
  endtask

  task automatic model_step();
    bit op [P];
    for (int p = 0; p < P; p++) op[p] = m_pend[p];
    for (int p = 0; p < P; p++) begin
      if (InReq_Abort[p]) m_pend[p] = 1'b0;
      else if (InReq_Valid[p] && !op[p]) begin
        m_pend[p] = 1'b1;
        m_addr[p] = InReq_Addr[p*AW +: AW];
        m_type[p] = InReq_DataType[p*TW +: TW];
      end
    end
    if (m_phase != 0) begin
      m_phase = 0; m_cur = -1;
    end else if (m_cur >= 0) begin
      if (OutResp_Done) begin
        m_pend[m_cur] = 1'b0; m_last = m_cur; m_cur = -1;
      end else if (InReq_Abort[m_cur]) begin
        m_pend[m_cur] = 1'b0; m_last = m_cur; m_phase = 1;
      end else if (m_age == TO) begin
        m_pend[m_cur] = 1'b0; m_last = m_cur; m_phase = 2;
      end else m_age++;
    end else if (OutResp_Ready) begin
      for (int k = 1; k <= P; k++) begin
        int q;
        q = (m_last + k) % P;
        if (op[q] && !InReq_Abort[q]) begin
          m_cur = q; m_gid = q; m_age = 1;
          break;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic compare();
    logic [P-1:0] ed, ee;
    logic ev, eab;
    ev  = (m_cur >= 0) && (m_phase == 0);
    eab = (m_phase != 0);
    ed = '0; ee = '0;
    if (m_cur >= 0 && m_phase == 0 && OutResp_Done) ed = P'(1) << m_cur;
    if (m_cur >= 0 && m_phase == 2) begin
      ed = P'(1) << m_cur; ee = P'(1) << m_cur;
    end
    chk("out_valid",  64'(OutReq_Valid), 64'(ev));
    chk("out_abort",  64'(OutReq_Abort), 64'(eab));
    chk("grant_id",   64'(Grant_Id), 64'(m_gid));
    chk("resp_done",  64'(InResp_Done), 64'(ed));
    chk("resp_err",   64'(InResp_Err), 64'(ee));
    chk("resp_ready", 64'(InResp_Ready), 64'({P{OutResp_Ready}}));
    if (ev) begin
      chk("out_addr", 64'(OutReq_Addr), 64'(m_addr[m_cur]));
      chk("out_type", 64'(OutReq_DataType), 64'(m_type[m_cur]));
    end
    if (ed != '0) chk("resp_data", InResp_Data, (m_phase == 2) ? 64'd0 : OutResp_Data);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) compare();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    InReq_Valid = '0; InReq_Addr = '0; InReq_DataType = '0; InReq_Abort = '0;
    OutResp_Done = 1'b0; OutResp_Data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [TW-1:0] t);
    InReq_Valid[p] = 1'b1;
    InReq_Addr[p*AW +: AW] = a;
    InReq_DataType[p*TW +: TW] = t;
  endtask

  int grants[$];
  int exp_order[6];
  bit seen;

  initial begin
    rst = 1'b1;
    OutResp_Ready = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(OutReq_Valid), 64'd0);
    chk("rst_abort", 64'(OutReq_Abort), 64'd0);
    chk("rst_gid",   64'(Grant_Id), 64'd0);
    chk("rst_done",  64'(InResp_Done), 64'd0);
    rst = 1'b0;

    // Single request on port 2.
    OutResp_Ready = 1'b1;
    cyc(); set_req(2, 56'h1000, 3'd3);
    cyc(); InReq_Valid = '0; #1;
    chk("single_t1_valid", 64'(OutReq_Valid), 64'd0);
    cyc(); #1;
    chk("single_t2_valid", 64'(OutReq_Valid), 64'd1);
    chk("single_t2_addr",  64'(OutReq_Addr), 64'h1000);
    chk("single_t2_type",  64'(OutReq_DataType), 64'd3);
    chk("single_t2_gid",   64'(Grant_Id), 64'd2);
    cyc(); cyc();
    cyc(); OutResp_Done = 1'b1; OutResp_Data = 64'hDEAD_BEEF; #1;
    chk("single_done", 64'(InResp_Done), 64'b0100);
    chk("single_data", InResp_Data, 64'hDEAD_BEEF);
    cyc(); OutResp_Done = 1'b0; OutResp_Data = '0; #1;
    chk("single_t6_valid", 64'(OutReq_Valid), 64'd0);

    // Fairness: all ports requesting, Done in the third BUSY cycle.
    do_reset();
    for (int p = 0; p < P; p++) set_req(p, AW'(p * 256 + 16), TW'(p));
    grants.delete();
    for (int g = 0; g < 6; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        cyc(); #1;
        if (OutReq_Valid) seen = 1'b1;
      end
      chk("fair_wait", 64'(seen), 64'd1);
      grants.push_back(int'(Grant_Id));
      cyc(); cyc(); OutResp_Done = 1'b1;
      cyc(); OutResp_Done = 1'b0;
    end
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) chk("fair_grant", 64'(grants[i]), 64'(exp_order[i]));
    do_reset();

    // Requester abort on port 1 while port 3 waits.
    cyc(); set_req(1, 56'h2000, 3'd1); set_req(3, 56'h3000, 3'd2);
    cyc(); InReq_Valid = '0;
    cyc(); #1;
    chk("rab_gid1", 64'(Grant_Id), 64'd1);
    cyc(); InReq_Abort = 4'b0010;
    cyc(); InReq_Abort = '0; #1;
    chk("rab_abort",    64'(OutReq_Abort), 64'd1);
    chk("rab_valid_lo", 64'(OutReq_Valid), 64'd0);
    chk("rab_no_done",  64'(InResp_Done), 64'd0);
    cyc(); #1;
    chk("rab_abort_end", 64'(OutReq_Abort), 64'd0);
    cyc(); #1;
    chk("rab_valid3", 64'(OutReq_Valid), 64'd1);
    chk("rab_gid3",   64'(Grant_Id), 64'd3);
    chk("rab_addr3",  64'(OutReq_Addr), 64'h3000);
    cyc(); OutResp_Done = 1'b1;
    cyc(); OutResp_Done = 1'b0;

    // Watchdog timeout on port 0 (eight BUSY cycles without Done).
    cyc(); set_req(0, 56'hABC, 3'd5);
    cyc(); InReq_Valid = '0;
    cyc(); OutResp_Data = 64'h1234; #1;
    chk("tmo_gid0", 64'(Grant_Id), 64'd0);
    repeat (7) cyc();
    #1;
    chk("tmo_busy8_valid", 64'(OutReq_Valid), 64'd1);
    chk("tmo_busy8_abort", 64'(OutReq_Abort), 64'd0);
    cyc(); #1;
    chk("tmo_abort", 64'(OutReq_Abort), 64'd1);
    chk("tmo_done",  64'(InResp_Done), 64'b0001);
    chk("tmo_err",   64'(InResp_Err), 64'b0001);
    chk("tmo_data",  InResp_Data, 64'd0);
    cyc(); OutResp_Data = '0; #1;
    chk("tmo_after", 64'(OutReq_Abort), 64'd0);

    // Done and Abort together on port 2: normal completion wins.
    cyc(); set_req(2, 56'h4400, 3'd6);
    cyc(); InReq_Valid = '0;
    cyc(); cyc(); OutResp_Done = 1'b1; OutResp_Data = 64'h55; InReq_Abort = 4'b0100; #1;
    chk("sim_done", 64'(InResp_Done), 64'b0100);
    cyc(); OutResp_Done = 1'b0; OutResp_Data = '0; InReq_Abort = '0; #1;
    chk("sim_no_abort", 64'(OutReq_Abort), 64'd0);
    // Valid and Abort together on an idle port: nothing captured.
    cyc(); set_req(1, 56'h5500, 3'd2); InReq_Abort = 4'b0010;
    cyc(); InReq_Valid = '0; InReq_Abort = '0;
    cyc(); cyc(); #1;
    chk("va_not_captured", 64'(OutReq_Valid), 64'd0);

    // Backpressure: no grant while the target is not ready.
    OutResp_Ready = 1'b0;
    cyc(); set_req(3, 56'h6600, 3'd4);
    cyc(); InReq_Valid = '0;
    repeat (3) cyc();
    #1;
    chk("bp_hold", 64'(OutReq_Valid), 64'd0);
    OutResp_Ready = 1'b1;
    cyc(); #1;
    chk("bp_grant_valid", 64'(OutReq_Valid), 64'd1);
    chk("bp_grant_gid",   64'(Grant_Id), 64'd3);

    // Reset in the middle of the transaction, then port 0 wins first.
    cyc(); #2;
    rst = 1'b1; #1;
    chk("arst_valid", 64'(OutReq_Valid), 64'd0);
    chk("arst_abort", 64'(OutReq_Abort), 64'd0);
    chk("arst_addr",  64'(OutReq_Addr), 64'd0);
    chk("arst_gid",   64'(Grant_Id), 64'd0);
    chk("arst_ready", 64'(InResp_Ready), 64'd0);
    cyc(); cyc();
    rst = 1'b0;
    set_req(0, 56'h7000, 3'd1); set_req(3, 56'h7300, 3'd3);
    cyc(); InReq_Valid = '0;
    cyc(); #1;
    chk("post_rst_gid",   64'(Grant_Id), 64'd0);
    chk("post_rst_valid", 64'(OutReq_Valid), 64'd1);
    cyc(); OutResp_Done = 1'b1;
    cyc(); OutResp_Done = 1'b0;
    repeat (6) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
